// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative radix-2 multiply/divide with HI/LO registers.
// Sits beside the EX-stage ALU and stalls HI/LO-class ops while busy.
module muldiv_hilo_unit #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [5:0]       funct,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] a_raw_q;
  logic             is_div_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic             div0_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  logic             is_hilo;
  logic             is_md;
  logic             is_mthi;
  logic             is_mtlo;
  logic             accept;
  logic             start;
  logic             sgn_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Classify funct into the HI/LO instruction group
  always_comb begin
    is_hilo = 1'b0;
    is_md   = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    unique case (funct)
      6'd16, 6'd18: is_hilo = 1'b1;
      6'd17: begin
        is_hilo = 1'b1;
        is_mthi = 1'b1;
      end
      6'd19: begin
        is_hilo = 1'b1;
        is_mtlo = 1'b1;
      end
      6'd24, 6'd25, 6'd26, 6'd27: begin
        is_hilo = 1'b1;
        is_md   = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign stall  = valid & busy & ~flush & is_hilo;
  assign accept = valid & ~stall & ~flush;
  assign start  = accept & is_md;

  // funct[0] marks the unsigned forms, funct[1] the divides
  assign sgn_op = SIGNED_EN & ~funct[0];
  assign a_neg  = sgn_op & op_a[WIDTH-1];
  assign b_neg  = sgn_op & op_b[WIDTH-1];
  assign mag_a  = a_neg ? -op_a : op_a;
  assign mag_b  = b_neg ? -op_b : op_b;

  // One shift-add or restoring-subtract step
  always_comb begin
    mul_sum = {1'b0, acc_hi_q};
    if (acc_lo_q[0]) begin
      mul_sum = {1'b0, acc_hi_q} + {1'b0, opnd_q};
    end
    div_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, opnd_q});
    div_sub = div_sh[WIDTH-1:0] - opnd_q;
  end

  // Sign correction and special cases applied in FIX
  always_comb begin
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_q_q ? -prod : prod;
    quo_fix  = neg_q_q ? -acc_lo_q : acc_lo_q;
    rem_fix  = neg_r_q ? -acc_hi_q : acc_hi_q;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      if (div0_q) begin
        fix_hi = a_raw_q;
        fix_lo = '1;
      end else begin
        fix_hi = rem_fix;
        fix_lo = quo_fix;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture and per-cycle iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
    end else if (start) begin
      cnt_q    <= CW'(WIDTH);
      acc_hi_q <= '0;
      acc_lo_q <= funct[1] ? mag_a : mag_b;
      opnd_q   <= funct[1] ? mag_b : mag_a;
      a_raw_q  <= op_a;
      is_div_q <= funct[1];
      neg_q_q  <= a_neg ^ b_neg;
      neg_r_q  <= a_neg;
      div0_q   <= (op_b == '0);
    end else if (state_q == RUN && !flush) begin
      cnt_q <= cnt_q - CW'(1);
      if (is_div_q) begin
        acc_hi_q <= div_ge ? div_sub : div_sh[WIDTH-1:0];
        acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ge};
      end else begin
        acc_hi_q <= mul_sum[WIDTH:1];
        acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
      end
    end
  end

  // HI/LO registers: MTHI/MTLO writes and FIX result writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == FIX) & ~flush;
      if (state_q == FIX && !flush) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end else begin
        if (accept && is_mthi) hi_q <= op_a;
        if (accept && is_mtlo) lo_q <= op_a;
      end
    end
  end

  // MFHI/MFLO read path
  always_comb begin
    rd_data = '0;
    if (funct == 6'd16) rd_data = hi_q;
    if (funct == 6'd18) rd_data = lo_q;
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb_muldiv_hilo_unit: vector table, hand sequences and random ops
// against an arithmetic reference model, on a 32-bit and an 8-bit unit.
module tb_muldiv_hilo_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v1, fl1;
  logic [5:0]  f1;
  logic [31:0] a1, b1;
  logic        busy1, done1, stall1;
  logic [31:0] hi1, lo1, rd1;

  logic        v2, fl2;
  logic [5:0]  f2;
  logic [7:0]  a2, b2;
  logic        busy2, done2, stall2;
  logic [7:0]  hi2, lo2, rd2;

  muldiv_hilo_unit #(.WIDTH(32), .SIGNED_EN(1'b1)) u32 (
    .clk(clk), .rst_n(rst_n), .valid(v1), .funct(f1), .flush(fl1),
    .op_a(a1), .op_b(b1), .busy(busy1), .done(done1), .stall(stall1),
    .hi(hi1), .lo(lo1), .rd_data(rd1)
  );

  muldiv_hilo_unit #(.WIDTH(8), .SIGNED_EN(1'b0)) u8 (
    .clk(clk), .rst_n(rst_n), .valid(v2), .funct(f2), .flush(fl2),
    .op_a(a2), .op_b(b2), .busy(busy2), .done(done2), .stall(stall2),
    .hi(hi2), .lo(lo2), .rd_data(rd2)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          w8;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    string       nm;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit w8, input logic v, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      v2 = v; f2 = f; a2 = a[7:0]; b2 = b[7:0];
    end else begin
      v1 = v; f1 = f; a1 = a; b1 = b;
    end
  endtask

  function automatic logic busy_of(input bit w8);
    return w8 ? busy2 : busy1;
  endfunction

  function automatic logic done_of(input bit w8);
    return w8 ? done2 : done1;
  endfunction

  function automatic logic [31:0] hi_of(input bit w8);
    return w8 ? {24'd0, hi2} : hi1;
  endfunction

  function automatic logic [31:0] lo_of(input bit w8);
    return w8 ? {24'd0, lo2} : lo1;
  endfunction

  // Reference: plain integer arithmetic on the architectural rules
  task automatic model(input bit w8, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    int          w;
    bit          sg, dv;
    logic [63:0] m, ua, ub, r64;
    longint      sa, sb, q, r;
    w  = w8 ? 8 : 32;
    m  = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & m;
    ub = {32'd0, b} & m;
    sa = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    sg = !w8 && (f == 6'd24 || f == 6'd26);
    dv = (f == 6'd26 || f == 6'd27);
    if (!dv) begin
      r64 = sg ? 64'(sa * sb) : ua * ub;
      eh  = 32'((r64 >> w) & m);
      el  = 32'(r64 & m);
    end else if (ub == 64'd0) begin
      eh = 32'(ua);
      el = 32'(m);
    end else if (sg) begin
      q  = sa / sb;
      r  = sa % sb;
      el = 32'(64'(q) & m);
      eh = 32'(64'(r) & m);
    end else begin
      el = 32'(ua / ub);
      eh = 32'(ua % ub);
    end
  endtask

  task automatic check_op(input bit w8, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input string nm);
    int cyc;
    @(negedge clk);
    drive(w8, 1'b1, f, a, b);
    @(negedge clk);
    drive(w8, 1'b0, 6'd0, 32'd0, 32'd0);
    cyc = 0;
    while (busy_of(w8) && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    chk({nm, " busy_cycles"}, cyc, w8 ? 32'd9 : 32'd33);
    chk({nm, " done"}, {31'd0, done_of(w8)}, 32'd1);
    chk({nm, " hi"}, hi_of(w8), eh);
    chk({nm, " lo"}, lo_of(w8), el);
  endtask

  initial begin
    logic [31:0] eh, el;
    int          sc, dc;

    tbl[0]  = '{0, 6'd27, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7"};
    tbl[1]  = '{0, 6'd24, 32'hFFFFFFFD, 32'd5,
                32'hFFFFFFFF, 32'hFFFFFFF1, "mult_m3_5"};
    tbl[2]  = '{0, 6'd26, 32'hFFFFFFF9, 32'd2,
                32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2"};
    tbl[3]  = '{0, 6'd27, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, "divu_by0"};
    tbl[4]  = '{0, 6'd26, 32'h80000000, 32'hFFFFFFFF,
                32'd0, 32'h80000000, "div_min_m1"};
    tbl[5]  = '{0, 6'd26, 32'hFFFFFFF9, 32'd0,
                32'hFFFFFFF9, 32'hFFFFFFFF, "div_neg_by0"};
    tbl[6]  = '{0, 6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFE, 32'd1, "multu_max"};
    tbl[7]  = '{0, 6'd26, 32'd7, 32'hFFFFFFFE,
                32'd1, 32'hFFFFFFFD, "div_7_m2"};
    tbl[8]  = '{0, 6'd24, 32'hFFFFFFF9, 32'hFFFFFFFA,
                32'd0, 32'd42, "mult_m7_m6"};
    tbl[9]  = '{1, 6'd26, 32'hF9, 32'd2, 32'h01, 32'h7C, "w8_unsgn_div"};
    tbl[10] = '{1, 6'd25, 32'hFF, 32'hFF, 32'hFE, 32'h01, "w8_multu_ff"};
    tbl[11] = '{1, 6'd24, 32'hFD, 32'd5, 32'h04, 32'hF1, "w8_unsgn_mul"};

    rst_n = 1'b0;
    v1 = 0; f1 = 0; fl1 = 0; a1 = 0; b1 = 0;
    v2 = 0; f2 = 0; fl2 = 0; a2 = 0; b2 = 0;
    #12;
    chk("rst busy", {31'd0, busy1}, 32'd0);
    chk("rst done", {31'd0, done1}, 32'd0);
    chk("rst stall", {31'd0, stall1}, 32'd0);
    chk("rst hi", hi1, 32'd0);
    chk("rst lo", lo1, 32'd0);
    chk("rst hi8", {24'd0, hi2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      check_op(tbl[i].w8, tbl[i].f, tbl[i].a, tbl[i].b,
               tbl[i].eh, tbl[i].el, tbl[i].nm);
    end

    // MTHI / MTLO write and read back
    @(negedge clk);
    v1 = 1; f1 = 6'd17; a1 = 32'hA5A5;
    @(negedge clk);
    v1 = 0; f1 = 6'd16;
    #1 chk("mthi rd", rd1, 32'hA5A5);
    @(negedge clk);
    v1 = 1; f1 = 6'd19; a1 = 32'h5A5A;
    @(negedge clk);
    v1 = 0; f1 = 6'd18;
    #1 chk("mtlo rd", rd1, 32'h5A5A);
    chk("mtlo hi kept", hi1, 32'hA5A5);

    // MULTU followed by a stalled MFLO
    model(0, 6'd25, 32'h12345, 32'h777, eh, el);
    @(negedge clk);
    drive(0, 1'b1, 6'd25, 32'h12345, 32'h777);
    @(negedge clk);
    drive(0, 1'b1, 6'd18, 32'd0, 32'd0);
    sc = 0;
    while (stall1 && sc < 200) begin
      sc++;
      @(negedge clk);
    end
    chk("mflo stall_cycles", sc, 32'd33);
    chk("mflo rd", rd1, el);
    chk("mflo done", {31'd0, done1}, 32'd1);
    @(negedge clk);
    v1 = 0;
    chk("done one cycle", {31'd0, done1}, 32'd0);

    // MTHI while busy stalls and is applied after the result
    @(negedge clk);
    drive(0, 1'b1, 6'd27, 32'd1000, 32'd7);
    @(negedge clk);
    drive(0, 1'b1, 6'd17, 32'h1234, 32'd0);
    sc = 0;
    while (stall1 && sc < 200) begin
      sc++;
      @(negedge clk);
    end
    chk("mthi held hi", hi1, 32'd6);
    chk("mthi held lo", lo1, 32'd142);
    @(negedge clk);
    v1 = 0;
    chk("mthi after hi", hi1, 32'h1234);
    chk("mthi after lo", lo1, 32'd142);

    // Flush mid-divide
    @(negedge clk);
    drive(0, 1'b1, 6'd27, 32'd100, 32'd7);
    @(negedge clk);
    drive(0, 1'b0, 6'd0, 32'd0, 32'd0);
    repeat (9) @(negedge clk);
    fl1 = 1;
    @(negedge clk);
    fl1 = 0;
    chk("flush busy", {31'd0, busy1}, 32'd0);
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done1) dc++;
    end
    chk("flush no done", dc, 32'd0);
    chk("flush hi", hi1, 32'h1234);
    chk("flush lo", lo1, 32'd142);
    v1 = 1; f1 = 6'd17; a1 = 32'hBEEF; fl1 = 1;
    @(negedge clk);
    v1 = 0; fl1 = 0;
    chk("flush blocks mthi", hi1, 32'h1234);

    // Asynchronous reset mid-run
    @(negedge clk);
    drive(0, 1'b1, 6'd24, 32'd77, 32'd99);
    @(negedge clk);
    drive(0, 1'b0, 6'd0, 32'd0, 32'd0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", {31'd0, busy1}, 32'd0);
    chk("async rst hi", hi1, 32'd0);
    chk("async rst lo", lo1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back DIVU issued in the done cycle (8-bit unit)
    @(negedge clk);
    drive(1, 1'b1, 6'd27, 32'd200, 32'd7);
    @(negedge clk);
    drive(1, 1'b0, 6'd0, 32'd0, 32'd0);
    sc = 0;
    while (busy2 && sc < 200) begin
      sc++;
      @(negedge clk);
    end
    chk("b2b first done", {31'd0, done2}, 32'd1);
    chk("b2b first lo", {24'd0, lo2}, 32'd28);
    chk("b2b first hi", {24'd0, hi2}, 32'd4);
    drive(1, 1'b1, 6'd27, 32'd255, 32'd16);
    #1 chk("b2b no stall", {31'd0, stall2}, 32'd0);
    @(negedge clk);
    drive(1, 1'b0, 6'd0, 32'd0, 32'd0);
    sc = 0;
    while (busy2 && sc < 200) begin
      sc++;
      @(negedge clk);
    end
    chk("b2b busy_cycles", sc, 32'd9);
    chk("b2b second lo", {24'd0, lo2}, 32'd15);
    chk("b2b second hi", {24'd0, hi2}, 32'd15);

    // Random ops against the reference model
    for (int i = 0; i < 60; i++) begin
      bit          w8;
      logic [5:0]  f;
      logic [31:0] a, b;
      w8 = i[0];
      f  = 6'(24 + $urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 5));
      if (w8) begin
        a = a & 32'hFF;
        b = b & 32'hFF;
      end
      model(w8, f, a, b, eh, el);
      check_op(w8, f, a, b, eh, el, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
